mapper_mem_arbiter: RTL
=======================

// Module: mapper_mem_arbiter
// PURPOSE
//  Shares the single mapper memory port (ram_cs/addr/rnw/data) between the CPU-side mapper
//  path and the cartridge ROM loader. It runs one transaction at a time and grants round-robin.
//  Each transaction has a registered request, a wait-for-ready phase, a one-cycle ack and a recovery cycle.
//  Sits between the mapper modules and the SDRAM/BRAM controller. A watchdog aborts hung accesses.
// PARAMETERS
//  ADDR_W   27   memory address width (matches mapper addr)
//  DATA_W   8    data width
//  TIMEOUT  255  max WAIT cycles without mem_ready before abort (>=1)
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       async active-low reset
//  cpu_req     in   1       CPU requester: level, held until cpu_ack
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_rnw     in   1       1=read, 0=write
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       1-cycle completion pulse
//  cpu_rdata   out  DATA_W  read data, valid with cpu_ack, held until next CPU ack
//  ld_req      in   1       loader requester (write only): level, held until ld_ack
//  ld_addr     in   ADDR_W  loader address
//  ld_wdata    in   DATA_W  loader write data
//  ld_ack      out  1       1-cycle completion pulse
//  ram_cs      out  1       memory select
//  addr        out  ADDR_W  memory address
//  rnw         out  1       memory read/not-write
//  data        out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, valid with mem_ready
//  mem_ready   in   1       memory completion strobe
//  err_clr     in   1       clears err_timeout
//  err_timeout out  1       sticky: at least one transaction aborted by watchdog
// BEHAVIOUR
//  - Reset (async, reset_n=0) forces: state=IDLE, ram_cs=0, addr='1, rnw=1, data='1,
//    cpu_ack=ld_ack=0, cpu_rdata='1, err_timeout=0, last_grant=LD, wdog=0.
//  - Idle port value is the mapper idle convention: ram_cs=0, addr all ones, rnw=1, data all ones.
//    Memory outputs hold this value in every state except WAIT.
//  - States: IDLE -> WAIT -> ACK -> REC -> IDLE. All outputs are registered.
//  - IDLE: if any req is sampled, the grant goes to the requester not equal to last_grant.
//    If only one requester is pending, that one is granted. last_grant updates to the winner.
//    The same edge latches addr/rnw/data (loader: rnw=0), sets ram_cs=1 and enters WAIT.
//  - WAIT: ram_cs=1 and addr/rnw/data stay stable. mem_ready is sampled every edge, including
//    the first WAIT cycle.
//    - mem_ready=1: capture mem_rdata into cpu_rdata if the CPU is granted and rnw=1.
//      Drive idle values, pulse the winner's ack and go to ACK.
//    - Watchdog: wdog counts WAIT cycles. When wdog==TIMEOUT-1 and mem_ready=0, abort: drive idle
//      values, set err_timeout=1 and pulse the ack. For a CPU read, cpu_rdata='1. Go to ACK.
//  - ACK: ack high for exactly this one cycle. Go to REC.
//  - REC: one dead cycle so the requester can drop req. Go to IDLE.
//    A req still high in IDLE is a new request.
//  - Latency: req seen at edge E0; ram_cs high from E0. With mem_ready at the first WAIT edge E1,
//    ack is high E1..E2, REC E2..E3, and the next grant is at E3 at the earliest.
//    Throughput is 1 transaction / 3 cycles minimum.
//  - Simultaneous cpu_req and ld_req after reset: CPU wins first (last_grant=LD), then strict alternation.
//  - A req dropped mid-WAIT does not cancel: the access completes and the ack still pulses.
//  - mem_ready outside WAIT is ignored.
//  - err_clr and the set from a timeout in the same cycle: set wins.
//  - Requester inputs are sampled only in IDLE; changes during WAIT have no effect.
//  - Watchdog counter width is $clog2(TIMEOUT+1). It is cleared on entry to WAIT and never wraps.
// STRUCTURE
//  - Package mapper_arb_pkg holds:
//    - typedef enum logic [1:0] {IDLE, WAIT, ACK, REC} arb_state_t
//    - typedef enum logic {GNT_CPU, GNT_LD} arb_gnt_t
//    - typedef struct packed {addr, rnw, wdata} mem_req_t
//    - localparams IDLE_ADDR / IDLE_DATA (all ones)
//  - One sub-module, mapper_arb_wdog: loadable counter with clear, enable and expire output
//    (parameter TIMEOUT). The FSM and grant logic stay in the top module.
// TESTING
//  1. Reset release, no req -> ram_cs=0, addr=27'h7FFFFFF, rnw=1, data=8'hFF, acks 0, err_timeout=0.
//  2. CPU read addr 27'h0004000, mem_ready=1 in the first WAIT cycle with mem_rdata=8'hA5
//     -> ram_cs high for 1 cycle, cpu_ack 1 cycle later with cpu_rdata=8'hA5, next grant >=3 cycles after req.
//  3. cpu_req and ld_req high together and held, each accepted 4 times
//     -> grant order CPU, LD, CPU, LD...; the loader access always has rnw=0 and data=ld_wdata.
//  4. Loader write with mem_ready delayed 5 cycles -> addr/data stable for all 6 WAIT cycles, one ld_ack, no cpu_ack.
//  5. TIMEOUT=4, CPU read, mem_ready never -> abort after 4 WAIT cycles:
//     cpu_ack pulses, cpu_rdata=8'hFF, err_timeout=1 until err_clr; a stray mem_ready afterwards is ignored.
//  6. reset_n low mid-WAIT -> all outputs at reset values immediately (async); after release a new
//     cpu_req is granted cleanly.

Source files
------------

// File: rtl/mapper_arb_pkg.sv
// Shared types and idle-port constants for the mapper memory arbiter.
package mapper_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, REC} arb_state_t;
  typedef enum logic {GNT_CPU, GNT_LD} arb_gnt_t;

  localparam int MAP_ADDR_W = 27;
  localparam int MAP_DATA_W = 8;

  typedef struct packed {
    logic [MAP_ADDR_W-1:0] addr;
    logic                  rnw;
    logic [MAP_DATA_W-1:0] wdata;
  } mem_req_t;

  localparam logic [MAP_ADDR_W-1:0] IDLE_ADDR = '1;
  localparam logic [MAP_DATA_W-1:0] IDLE_DATA = '1;

endpackage

// File: rtl/mapper_arb_wdog.sv
// WAIT-phase watchdog: counts while enabled, saturates at TIMEOUT-1 and flags expiry there.
module mapper_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mapper_mem_arbiter.sv
// Round-robin arbiter sharing the mapper memory port between the CPU path and the ROM loader.
// One transaction at a time: grant, wait for mem_ready (watchdog-bounded), ack, recovery.
module mapper_mem_arbiter
  import mapper_arb_pkg::*;
#(
  parameter int ADDR_W  = MAP_ADDR_W,
  parameter int DATA_W  = MAP_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rnw,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              ram_cs,
  output logic [ADDR_W-1:0] addr,
  output logic              rnw,
  output logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              err_clr,
  output logic              err_timeout
);

  arb_state_t        state, state_nxt;
  arb_gnt_t          gnt, gnt_nxt, last_grant, last_nxt, win;
  logic              cs_nxt, rnw_nxt, cpu_ack_nxt, ld_ack_nxt, err_nxt, err_set;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt, rdata_nxt;
  logic              wdog_clr, wdog_en, wdog_expire;

  mapper_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .expire (wdog_expire)
  );

  always_comb begin
    if (cpu_req && ld_req) win = (last_grant == GNT_LD) ? GNT_CPU : GNT_LD;
    else if (cpu_req)      win = GNT_CPU;
    else                   win = GNT_LD;
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    last_nxt    = last_grant;
    cs_nxt      = 1'b0;
    addr_nxt    = '1;
    rnw_nxt     = 1'b1;
    data_nxt    = '1;
    cpu_ack_nxt = 1'b0;
    ld_ack_nxt  = 1'b0;
    rdata_nxt   = cpu_rdata;
    err_set     = 1'b0;
    wdog_clr    = 1'b0;
    wdog_en     = 1'b0;
    case (state)
      // REC's exit edge doubles as the first IDLE sample, giving a 3-cycle grant spacing.
      IDLE, REC: begin
        state_nxt = IDLE;
        if (cpu_req || ld_req) begin
          state_nxt = WAIT;
          gnt_nxt   = win;
          last_nxt  = win;
          cs_nxt    = 1'b1;
          wdog_clr  = 1'b1;
          if (win == GNT_CPU) begin
            addr_nxt = cpu_addr;
            rnw_nxt  = cpu_rnw;
            data_nxt = cpu_wdata;
          end else begin
            addr_nxt = ld_addr;
            rnw_nxt  = 1'b0;
            data_nxt = ld_wdata;
          end
        end
      end
      WAIT: begin
        wdog_en = 1'b1;
        if (mem_ready || wdog_expire) begin
          state_nxt   = ACK;
          cpu_ack_nxt = (gnt == GNT_CPU);
          ld_ack_nxt  = (gnt == GNT_LD);
          err_set     = !mem_ready;
          if ((gnt == GNT_CPU) && rnw) rdata_nxt = mem_ready ? mem_rdata : '1;
        end else begin
          cs_nxt   = 1'b1;
          addr_nxt = addr;
          rnw_nxt  = rnw;
          data_nxt = data;
        end
      end
      ACK:     state_nxt = REC;
      default: state_nxt = IDLE;
    endcase
    err_nxt = err_set | (err_timeout & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt         <= GNT_CPU;
      last_grant  <= GNT_LD;
      ram_cs      <= 1'b0;
      addr        <= '1;
      rnw         <= 1'b1;
      data        <= '1;
      cpu_ack     <= 1'b0;
      ld_ack      <= 1'b0;
      cpu_rdata   <= '1;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      last_grant  <= last_nxt;
      ram_cs      <= cs_nxt;
      addr        <= addr_nxt;
      rnw         <= rnw_nxt;
      data        <= data_nxt;
      cpu_ack     <= cpu_ack_nxt;
      ld_ack      <= ld_ack_nxt;
      cpu_rdata   <= rdata_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule
